serial_adder: RTL and testbench

- Bit-serial ripple adder built around a single full-adder cell, plus a carry flip-flop and operand/result shift registers.
- Consumes one bit pair per clock, LSB first, and produces a WIDTH-bit sum and carry-out after WIDTH cycles.
- Sits directly upstream of wider arithmetic datapaths. It serialises the full-adder stage for area-constrained use.
- Uses a start/busy/done handshake.

---
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell, a carry flop and operand/result shift
// registers. One bit pair is consumed per clock, LSB first; the WIDTH-bit sum and the
// carry-out are loaded into holding registers on the last bit and flagged with a done pulse.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   s_sr_q, s_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               fa_bit;
  logic               fa_carry;
  logic [WIDTH-1:0]   s_shift;

  // Full-adder cell on the current LSBs, and the result register with the new bit at the MSB.
  always_comb begin
    fa_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    fa_carry = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    // Shift form avoids an empty part-select when WIDTH is 1.
    s_shift  = (s_sr_q >> 1) | (WIDTH'(fa_bit) << (WIDTH - 1));
  end

  // Next-state logic: operand load on accepted start, one bit per cycle while shifting.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          s_sr_d  = '0;
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        // start is deliberately ignored here so an operation in flight is never disturbed.
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        s_sr_d  = s_shift;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          sum_d   = s_shift;
          cout_d  = fa_carry;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Handshake outputs decode directly from the registered state.
  always_comb begin
    busy = (state_q == StShift);
    done = (state_q == StDone);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 and a WIDTH=1 instance. Stimulus pushes the arithmetic
// result a+b+cin and the issue cycle into a queue; negedge monitors derive the expected
// busy/done timing from the issue cycle and compare sum/cout on done, and check that the
// outputs hold the last result in every other cycle.
module tb_serial_adder;

  localparam int unsigned W8 = 8;
  localparam int unsigned W1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n8, start8, cin8, busy8, done8, cout8;
  logic [W8-1:0] a8, b8, sum8;
  logic          rst_n1, start1, cin1, busy1, done1, cout1;
  logic [W1-1:0] a1, b1, sum1;

  serial_adder #(.WIDTH(W8), .CNT_W(6)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(W1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    int unsigned c;    // cycle count at the negedge where start was driven
    logic [32:0] res;  // {cout, sum}
  } exp_t;

  exp_t        q8[$];
  exp_t        q1[$];
  logic [32:0] held8 = '0;
  logic [32:0] held1 = '0;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor for the 8-bit instance.
  always @(negedge clk) begin
    logic        has;
    int unsigned c;
    if (cyc > 0) begin
      has = (q8.size() != 0);
      c   = has ? q8[0].c : 0;
      chk("done8", 33'(done8), 33'(has && cyc == c + W8 + 1));
      chk("busy8", 33'(busy8), 33'(has && cyc > c && cyc <= c + W8));
      if (has && cyc >= c + W8 + 1) begin
        if (done8) begin
          chk("result8", 33'({cout8, sum8}), q8[0].res);
          held8 = q8[0].res;
        end
        void'(q8.pop_front());
      end else begin
        chk("hold8", 33'({cout8, sum8}), held8);
      end
    end
  end

  // Scoreboard monitor for the 1-bit instance.
  always @(negedge clk) begin
    logic        has;
    int unsigned c;
    if (cyc > 0) begin
      has = (q1.size() != 0);
      c   = has ? q1[0].c : 0;
      chk("done1", 33'(done1), 33'(has && cyc == c + W1 + 1));
      chk("busy1", 33'(busy1), 33'(has && cyc > c && cyc <= c + W1));
      if (has && cyc >= c + W1 + 1) begin
        if (done1) begin
          chk("result1", 33'({cout1, sum1}), q1[0].res);
          held1 = q1[0].res;
        end
        void'(q1.pop_front());
      end else begin
        chk("hold1", 33'({cout1, sum1}), held1);
      end
    end
  end

  // Called at a negedge while the DUT is idle or done; start is seen at the next posedge.
  task automatic issue8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic ci);
    exp_t e;
    start8 = 1'b1;
    a8     = a;
    b8     = b;
    cin8   = ci;
    e.c    = cyc;
    e.res  = 33'(a) + 33'(b) + 33'(ci);
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    a8     = W8'($urandom);
    b8     = W8'($urandom);
    cin8   = 1'($urandom);
  endtask

  task automatic issue1(input logic [W1-1:0] a, input logic [W1-1:0] b, input logic ci);
    exp_t e;
    start1 = 1'b1;
    a1     = a;
    b1     = b;
    cin1   = ci;
    e.c    = cyc;
    e.res  = 33'(a) + 33'(b) + 33'(ci);
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    a1     = W1'($urandom);
    b1     = W1'($urandom);
    cin1   = 1'($urandom);
  endtask

  // Returns at the negedge where done is high, so a back-to-back start can follow at once.
  task automatic wait_done8();
    for (int n = 0; n < 40 && done8 !== 1'b1; n++) @(negedge clk);
    chk("wait_done8", 33'(done8), 33'd1);
  endtask

  task automatic wait_done1();
    for (int n = 0; n < 40 && done1 !== 1'b1; n++) @(negedge clk);
    chk("wait_done1", 33'(done1), 33'd1);
  endtask

  task automatic reset8();
    rst_n8 = 1'b0;
    @(posedge clk);
    q8.delete();
    held8 = '0;
    @(negedge clk);
    rst_n8 = 1'b1;
  endtask

  initial begin
    logic [2:0] v;
    rst_n8 = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst_n1 = 1'b0; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n8 = 1'b1;
    rst_n1 = 1'b1;
    repeat (2) @(negedge clk);

    // Basic add and full carry ripple cases.
    issue8(8'h3C, 8'h0F, 1'b0); wait_done8(); @(negedge clk);
    issue8(8'hFF, 8'h01, 1'b0); wait_done8(); @(negedge clk);
    issue8(8'hA5, 8'h5A, 1'b1); wait_done8(); @(negedge clk);

    // Start pulsed mid-operation must be ignored.
    issue8(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();

    // Back-to-back start in the done cycle; previous result must hold meanwhile.
    issue8(8'h01, 8'h01, 1'b0); wait_done8(); @(negedge clk);

    // Reset during the shift phase aborts, then a fresh add works.
    issue8(8'h55, 8'hAA, 1'b1);
    repeat (3) @(negedge clk);
    reset8();
    repeat (2) @(negedge clk);
    issue8(8'h7F, 8'h01, 1'b0); wait_done8(); @(negedge clk);

    // Random operands with random gaps, including back-to-back runs.
    for (int i = 0; i < 40; i++) begin
      issue8(W8'($urandom), W8'($urandom), 1'($urandom));
      wait_done8();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);

    // WIDTH=1: full-adder truth table, then back-to-back.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      issue1(v[2], v[1], v[0]); wait_done1(); @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      v = 3'($urandom);
      issue1(v[2], v[1], v[0]); wait_done1();
    end

    repeat (5) @(negedge clk);
    chk("drain8", 33'(q8.size()), 33'd0);
    chk("drain1", 33'(q1.size()), 33'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
